// File: rtl/rtc_clock_pkg.sv
// Shared definitions for the BCD real-time clock: field widths, wrap limits,
// reset time and the small conversion helpers used by the display path.
package rtc_clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    localparam logic [SEC_W-1:0] RST_SEC = 6'd0;
    localparam logic [MIN_W-1:0] RST_MIN = 6'd0;
    localparam logic [HR_W-1:0]  RST_HR  = 5'd12;
    localparam logic [HR_W-1:0]  NOON_HR = 5'd12;

    typedef enum logic {
        DB_ARMED,
        DB_WAIT_RELEASE
    } db_state_e;

    // Packs a 0..59 value as {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    function automatic logic [HR_W-1:0] display_hour(input logic [HR_W-1:0] hr,
                                                     input logic mode_24h);
        if (mode_24h)       return hr;
        if (hr == '0)       return NOON_HR;
        if (hr > NOON_HR)   return hr - NOON_HR;
        return hr;
    endfunction

endpackage

// File: rtl/rtc_bcd_clock_if.sv
// User-facing bundle of the clock: control inputs driven by the host side and
// the display outputs produced by the clock side.
interface rtc_bcd_clock_if;

    logic       mode_24h;
    logic       btn_inc_min;
    logic       btn_inc_hr;
    logic       tick_1Hz;
    logic       sec_pulse;
    logic       pm;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;

    modport master (
        output mode_24h, btn_inc_min, btn_inc_hr,
        input  tick_1Hz, sec_pulse, pm,
        input  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s
    );

    modport slave (
        input  mode_24h, btn_inc_min, btn_inc_hr,
        output tick_1Hz, sec_pulse, pm,
        output sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus press/release debouncer; emits one registered
// single-cycle pulse per accepted press.
module btn_debounce
    import rtc_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             want_lvl;

    // The same counter times a stable press while armed and a stable release afterwards.
    always_comb begin
        // NOTE: defaults first; every path then assigns every output, so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        want_lvl = (state_q == DB_ARMED) ? sync2_q : ~sync2_q;
        if (!want_lvl) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (state_q == DB_ARMED) begin
                pulse_d = 1'b1;
                state_d = DB_WAIT_RELEASE;
            end else begin
                state_d = DB_ARMED;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_ARMED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/rtc_bcd_clock.sv
// Binary-kept hh:mm:ss clock with 1 Hz prescaler, debounced set buttons and
// combinational BCD display in 12- or 24-hour form.
module rtc_bcd_clock
    import rtc_clock_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       mode_24h,
    input  logic       btn_inc_min,
    input  logic       btn_inc_hr,
    output logic       tick_1Hz,
    output logic       sec_pulse,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] hr_10s,
    output logic       pm
);

    localparam int               PRE_W    = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q, hr_d;
    logic             inc_min, inc_hr, hr_carry;
    logic [HR_W-1:0]  disp_hr;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_raw    (btn_inc_min),
        .press_pulse(inc_min)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hr (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_raw    (btn_inc_hr),
        .press_pulse(inc_hr)
    );

    assign sec_pulse = (pre_q == PRE_LAST);

    always_comb begin
        pre_d    = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        // Derived from the next prescaler value so the flop lines up with pre_q.
        tick_d   = (pre_d >= PRE_HALF);
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        hr_carry = 1'b0;
        if (inc_min) begin
            // A manual minute bump wins over the tick; its seconds carry is dropped.
            sec_d = '0;
            min_d = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
        end else if (sec_pulse) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d    = '0;
                    hr_carry = 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
        if (inc_hr || hr_carry) begin
            hr_d = (hr_q == HR_MAX) ? '0 : hr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            sec_q  <= RST_SEC;
            min_q  <= RST_MIN;
            hr_q   <= RST_HR;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
        end
    end

    assign tick_1Hz = tick_q;
    assign pm       = (hr_q >= NOON_HR);
    assign disp_hr  = display_hour(hr_q, mode_24h);

    assign {sec_10s, sec_1s} = to_bcd(sec_q);
    assign {min_10s, min_1s} = to_bcd(min_q);
    assign {hr_10s, hr_1s}   = to_bcd({1'b0, disp_hr});

endmodule
